// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer holding ALU results, branch
// resolution from FlagZ, youngest-first register forwarding and a retire counter.
module alu_wb_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic             in_flagz,
  input  logic [4:0]       in_rd,
  input  logic             in_wr_en,
  input  logic [1:0]       in_br_type,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [4:0]       out_rd,
  output logic             out_wr_en,
  output logic             out_br_taken,
  input  logic [4:0]       lookup_rs,
  output logic             fwd_hit,
  output logic [N-1:0]     fwd_data,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef struct packed {
    logic [N-1:0] result;
    logic [4:0]   rd;
    logic         wr_en;
    logic         br_taken;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_ent;
  logic   main_ld_in, main_ld_skid, skid_ld;
  logic   main_v, skid_v, accept, pop;

  assign main_v = (state != EMPTY);
  assign skid_v = (state == FULL);

  // reset_n in the term keeps in_ready low for the whole reset window
  assign in_ready = reset_n & ~skid_v & ~flush;
  assign accept   = in_valid & in_ready;
  assign pop      = main_v & out_ready;

  // qualify write enable and resolve the branch before storing
  always_comb begin
    in_ent.result = in_result;
    in_ent.rd     = in_rd;
    in_ent.wr_en  = in_wr_en & (in_rd != 5'd0);
    case (in_br_type)
      2'b01:   in_ent.br_taken = in_flagz;
      2'b10:   in_ent.br_taken = ~in_flagz;
      2'b11:   in_ent.br_taken = 1'b1;
      default: in_ent.br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          main_ld_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_ld_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          skid_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt    = ONE;
          main_ld_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // flush overrides; accept is already blocked through in_ready
    if (flush) begin
      state_nxt    = EMPTY;
      main_ld_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld_in)
        main_q <= in_ent;
      else if (main_ld_skid)
        main_q <= skid_q;
      if (skid_ld)
        skid_q <= in_ent;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (pop) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign out_valid    = main_v;
  assign out_result   = main_q.result;
  assign out_rd       = main_q.rd;
  assign out_wr_en    = main_q.wr_en;
  assign out_br_taken = main_q.br_taken;

  // skid holds the younger op, so it takes priority over main
  logic skid_hit, main_hit;
  assign skid_hit = (lookup_rs != 5'd0) & skid_v & skid_q.wr_en & (skid_q.rd == lookup_rs);
  assign main_hit = (lookup_rs != 5'd0) & main_v & main_q.wr_en & (main_q.rd == lookup_rs);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (skid_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_q.result;
    end else if (main_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = main_q.result;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: table vectors, directed corner sequences and random
// traffic against a queue-based reference model.
module tb_alu_wb_stage;
  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [N-1:0]     in_result = '0;
  logic             in_flagz = 1'b0;
  logic [4:0]       in_rd = '0;
  logic             in_wr_en = 1'b0;
  logic [1:0]       in_br_type = '0;
  logic             flush = 1'b0;
  logic             out_valid, out_ready = 1'b0;
  logic [N-1:0]     out_result;
  logic [4:0]       out_rd;
  logic             out_wr_en, out_br_taken;
  logic [4:0]       lookup_rs = '0;
  logic             fwd_hit;
  logic [N-1:0]     fwd_data;
  logic [CNT_W-1:0] retire_cnt;

  alu_wb_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flagz(in_flagz), .in_rd(in_rd), .in_wr_en(in_wr_en), .in_br_type(in_br_type),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_br_taken(out_br_taken),
    .lookup_rs(lookup_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] result;
    logic [4:0]   rd;
    logic         wr;
    logic         taken;
  } ent_t;

  ent_t             q[$];
  logic [CNT_W-1:0] cnt_m = '0;
  int               checks = 0, failures = 0;
  logic             last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [N-1:0] r, input logic z, input logic [4:0] rd,
                              input logic wr, input logic [1:0] br);
    ent_t e;
    e.result = r;
    e.rd     = rd;
    e.wr     = wr && (rd != 0);
    e.taken  = (br == 2'd1) ? z : (br == 2'd2) ? !z : (br == 2'd3);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] r, input logic z,
                       input logic [4:0] rd, input logic wr, input logic [1:0] br);
    in_valid = v; in_result = r; in_flagz = z; in_rd = rd; in_wr_en = wr; in_br_type = br;
  endtask

  // Called just after a negedge with inputs set: compare, advance model, move to next negedge.
  task automatic step();
    logic hit, acc, pp;
    logic [N-1:0] d;
    #1;
    chk("in_ready", in_ready, (q.size() < 2) && !flush);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_wr_en", out_wr_en, q[0].wr);
      chk("out_br_taken", out_br_taken, q[0].taken);
    end
    hit = 1'b0; d = '0;
    if (lookup_rs != 0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (!hit && q[i].wr && q[i].rd == lookup_rs) begin
          hit = 1'b1; d = q[i].result;
        end
    chk("fwd_hit", fwd_hit, hit);
    chk("fwd_data", fwd_data, d);
    chk("retire_cnt", retire_cnt, cnt_m);
    acc = in_valid && (q.size() < 2) && !flush;
    pp  = (q.size() > 0) && out_ready;
    last_acc = acc;
    if (pp) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(mk(in_result, in_flagz, in_rd, in_wr_en, in_br_type));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_retire_cnt", retire_cnt, '0);
    chk("rst_out_result", out_result, '0);
    q.delete(); cnt_m = '0;
    drive(0, '0, 0, 0, 0, 0); flush = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       z;
    logic [1:0] br;
    logic [4:0] rd;
    logic       wr;
    logic       exp_taken;
    logic       exp_wr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 2'b01, 5'd4, 1, 1, 1};
    vecs[1] = '{1, 2'b10, 5'd4, 1, 0, 1};
    vecs[2] = '{1, 2'b11, 5'd7, 0, 1, 0};
    vecs[3] = '{0, 2'b01, 5'd9, 1, 0, 1};
    vecs[4] = '{0, 2'b10, 5'd9, 1, 1, 1};
    vecs[5] = '{0, 2'b00, 5'd2, 1, 0, 1};
    vecs[6] = '{1, 2'b11, 5'd0, 1, 1, 0};
    vecs[7] = '{0, 2'b00, 5'd0, 0, 0, 0};

    @(negedge clk);
    do_reset();

    // single op
    out_ready = 1'b1;
    drive(1, 32'h0000_0005, 0, 5'd3, 1, 0);
    step();
    drive(0, '0, 0, 0, 0, 0);
    chk("t1_out_valid_next", out_valid, 1'b1);
    step();
    step();
    chk("t1_cnt", retire_cnt, 4'd1);

    // backpressure, order preservation
    out_ready = 1'b0;
    drive(1, 32'hA, 0, 5'd1, 1, 0); step();
    drive(1, 32'hB, 0, 5'd2, 1, 0); step();
    chk("t2_in_ready_full", in_ready, 1'b0);
    drive(1, 32'hC, 0, 5'd3, 1, 0); step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) drive(0, '0, 0, 0, 0, 0);
    end
    chk("t2_cnt", retire_cnt, 4'd4);

    // branch / write-enable table
    foreach (vecs[i]) begin
      drive(1, 32'h100 + i, vecs[i].z, vecs[i].rd, vecs[i].wr, vecs[i].br);
      step();
      drive(0, '0, 0, 0, 0, 0);
      #1;
      chk("tbl_taken", out_br_taken, vecs[i].exp_taken);
      chk("tbl_wr_en", out_wr_en, vecs[i].exp_wr);
      step();
    end

    // forwarding, skid wins
    out_ready = 1'b0;
    drive(1, 32'h11, 0, 5'd5, 1, 0); step();
    drive(1, 32'h22, 0, 5'd5, 1, 0); step();
    drive(0, '0, 0, 0, 0, 0);
    lookup_rs = 5'd5;
    #1;
    chk("t4_hit", fwd_hit, 1'b1);
    chk("t4_data", fwd_data, 32'h22);
    step();
    lookup_rs = 5'd0;
    step();

    // flush while full with pop
    begin
      logic [CNT_W-1:0] c0;
      c0 = retire_cnt;
      out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("t5_cnt", retire_cnt, c0 + 1'b1);
      chk("t5_out_valid", out_valid, 1'b0);
      chk("t5_in_ready", in_ready, 1'b1);
      step();
    end

    // wrap: 17 pops from reset
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, i, 0, 5'd6, 1, 0);
      step();
    end
    drive(0, '0, 0, 0, 0, 0);
    step();
    chk("t6_wrap", retire_cnt, 4'd1);

    // reset mid-stream
    out_ready = 1'b0;
    drive(1, 32'h77, 0, 5'd8, 1, 0); step();
    drive(0, '0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_cnt", retire_cnt, '0);
    @(negedge clk);
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      lookup_rs = $urandom_range(0, 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
